// File: rtl/frame_flip_controller.sv
// Tear-free page-flip controller: holds a software flip request until the start of vertical blank,
// counts frames and raises a vblank interrupt. FRAME_FLIP_COUNTER_EN builds the FRAME_COUNT register.
module frame_flip_controller #(
   parameter logic [31:0] BASE_ADDRESS = 32'hFF20_0600,
   parameter int unsigned V_VISIBLE    = 480
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] bus_address,
   input  logic [31:0] bus_write_data,
   input  logic [3:0]  bus_byte_enable,
   input  logic        bus_read_enable,
   input  logic        bus_write_enable,
   output logic [31:0] bus_data_fetched,
   input  logic [9:0]  pixel_y_pos,
   output logic        frame_select,
   output logic        vblank_irq
);

   typedef enum logic {
      IDLE,
      PENDING
   } flip_state_t;

   flip_state_t state;
   logic        target;
   logic        irq_en;
   logic        irq_flag;
   logic        irq_flag_next;
   logic        vb_now;
   logic        vb_r;
   logic        vb_q;
   logic        vb_edge;
   logic        flip_now;
   logic        frame_select_next;
   logic        addr_hit;
   logic [1:0]  reg_sel;
   logic        ctrl_wr;
   logic        status_wr;
   logic [31:0] rd_mux;
   logic [31:0] frame_count;
   logic        unused_bits;

   assign unused_bits = ^{bus_byte_enable[3:1], bus_write_data[31:3], bus_address[1:0]};

   assign reg_sel   = bus_address[3:2];
   assign addr_hit  = (bus_address[31:4] == BASE_ADDRESS[31:4]) && (reg_sel != 2'd3);
   assign ctrl_wr   = bus_write_enable && addr_hit && bus_byte_enable[0] && (reg_sel == 2'd0);
   assign status_wr = bus_write_enable && addr_hit && bus_byte_enable[0] && (reg_sel == 2'd1);

   assign vb_now  = (32'(pixel_y_pos) >= 32'(V_VISIBLE));
   assign vb_edge = vb_r & ~vb_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         vb_r <= 1'b0;
         vb_q <= 1'b0;
      end else begin
         vb_r <= vb_now;
         vb_q <= vb_r;
      end
   end

   // The edge resolves against the pre-write state; a coincident CTRL write is then judged
   // against the frame that is displayed after this edge.
   assign flip_now          = (state == PENDING) && vb_edge;
   assign frame_select_next = flip_now ? target : frame_select;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         target       <= 1'b0;
         frame_select <= 1'b0;
      end else begin
         frame_select <= frame_select_next;
         if (ctrl_wr) begin
            target <= bus_write_data[0];
            state  <= (bus_write_data[0] != frame_select_next) ? PENDING : IDLE;
         end else if (flip_now) begin
            state <= IDLE;
         end
      end
   end

   always_comb begin
      irq_flag_next = irq_flag;
      if (status_wr && bus_write_data[2]) irq_flag_next = 1'b0;
      if (vb_edge)                        irq_flag_next = 1'b1;
   end

   // The interrupt uses the enable held before this edge, so enabling on the edge cycle
   // does not count for that edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         irq_en     <= 1'b0;
         irq_flag   <= 1'b0;
         vblank_irq <= 1'b0;
      end else begin
         irq_flag   <= irq_flag_next;
         vblank_irq <= irq_flag_next & irq_en;
         if (ctrl_wr) irq_en <= bus_write_data[1];
      end
   end

`ifdef FRAME_FLIP_COUNTER_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         frame_count <= '0;
      end else if (vb_edge) begin
         frame_count <= frame_count + 32'd1;
      end
   end
`else
   assign frame_count = '0;
`endif

   always_comb begin
      rd_mux = '0;
      case (reg_sel)
         2'd0:    rd_mux[1:0] = {irq_en, target};
         2'd1:    rd_mux[2:0] = {irq_flag, (state == PENDING), frame_select};
         2'd2:    rd_mux      = frame_count;
         default: rd_mux      = '0;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         bus_data_fetched <= '0;
      end else if (bus_read_enable && addr_hit) begin
         bus_data_fetched <= rd_mux;
      end else begin
         bus_data_fetched <= '0;
      end
   end

endmodule

// File: tb/tb_frame_flip_controller.sv
// Directed bench for frame_flip_controller: a per-cycle reference model of the register file,
// flip request and vblank history, plus literal checks of the key scenarios.
module tb_frame_flip_controller;

   localparam logic [31:0] BASE   = 32'hFF20_0600;
   localparam logic [31:0] CTRL   = BASE + 32'h0;
   localparam logic [31:0] STATUS = BASE + 32'h4;
   localparam logic [31:0] FCOUNT = BASE + 32'h8;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] bus_address = '0;
   logic [31:0] bus_write_data = '0;
   logic [3:0]  bus_byte_enable = '0;
   logic        bus_read_enable = 1'b0;
   logic        bus_write_enable = 1'b0;
   logic [31:0] bus_data_fetched;
   logic [9:0]  pixel_y_pos = '0;
   logic        frame_select;
   logic        vblank_irq;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   frame_flip_controller #(.BASE_ADDRESS(BASE), .V_VISIBLE(480)) dut (
      .clock(clock), .reset(reset),
      .bus_address(bus_address), .bus_write_data(bus_write_data),
      .bus_byte_enable(bus_byte_enable), .bus_read_enable(bus_read_enable),
      .bus_write_enable(bus_write_enable), .bus_data_fetched(bus_data_fetched),
      .pixel_y_pos(pixel_y_pos), .frame_select(frame_select), .vblank_irq(vblank_irq)
   );

   always #5 clock = ~clock;

   // Reference model state
   logic        m_fs, m_tgt, m_pend, m_en, m_flag, m_irq;
   logic [31:0] m_cnt, m_rd;
   int          m_y1, m_y2;

   initial begin
      m_fs = 0; m_tgt = 0; m_pend = 0; m_en = 0; m_flag = 0; m_irq = 0;
      m_cnt = 0; m_rd = 0; m_y1 = 0; m_y2 = 0;
      forever begin
         @(posedge clock);
         begin
            logic        at_vb_start, en_before, hit, wr;
            logic [1:0]  off;
            logic [31:0] rdv;
            cyc++;
            if (!reset) begin
               m_fs = 0; m_tgt = 0; m_pend = 0; m_en = 0; m_flag = 0; m_irq = 0;
               m_cnt = 0; m_rd = 0; m_y1 = 0; m_y2 = 0;
            end else begin
               // vblank starts acting two clocks after the line number first reaches 480
               at_vb_start = (m_y1 >= 480) && (m_y2 < 480);
               off = bus_address[3:2];
               hit = (bus_address[31:4] == BASE[31:4]) && (off != 2'd3);
               wr  = bus_write_enable && hit && bus_byte_enable[0];
               rdv = 0;
               if (bus_read_enable && hit) begin
                  if (off == 2'd0) rdv = {30'd0, m_en, m_tgt};
                  else if (off == 2'd1) rdv = {29'd0, m_flag, m_pend, m_fs};
`ifdef FRAME_FLIP_COUNTER_EN
                  else rdv = m_cnt;
`endif
               end
               en_before = m_en;
               if (at_vb_start && m_pend) begin
                  m_fs = m_tgt;
                  m_pend = 0;
               end
               if (wr && off == 2'd0) begin
                  m_tgt  = bus_write_data[0];
                  m_en   = bus_write_data[1];
                  m_pend = (m_tgt != m_fs);
               end
               if (wr && off == 2'd1 && bus_write_data[2]) m_flag = 0;
               if (at_vb_start) begin
                  m_flag = 1;
                  m_cnt  = m_cnt + 1;
               end
               m_irq = m_flag & en_before;
               m_rd  = rdv;
               m_y2  = m_y1;
               m_y1  = int'(pixel_y_pos);
            end
         end
         #1;
         n_cmp++;
         if (frame_select !== m_fs) begin
            n_err++;
            $display("FAIL cyc %0d frame_select: got %0b want %0b", cyc, frame_select, m_fs);
         end
         n_cmp++;
         if (vblank_irq !== m_irq) begin
            n_err++;
            $display("FAIL cyc %0d vblank_irq: got %0b want %0b", cyc, vblank_irq, m_irq);
         end
         n_cmp++;
         if (bus_data_fetched !== m_rd) begin
            n_err++;
            $display("FAIL cyc %0d bus_data_fetched: got %h want %h", cyc, bus_data_fetched, m_rd);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      @(negedge clock);
      bus_address = a; bus_write_data = d; bus_byte_enable = be; bus_write_enable = 1'b1;
      @(negedge clock);
      bus_write_enable = 1'b0; bus_byte_enable = '0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] v);
      @(negedge clock);
      bus_address = a; bus_read_enable = 1'b1;
      @(posedge clock);
      #1 v = bus_data_fetched;
      @(negedge clock);
      bus_read_enable = 1'b0;
   endtask

   task automatic sety(input int v);
      @(negedge clock);
      pixel_y_pos = 10'(v);
   endtask

   task automatic run_frame();
      sety(100); repeat (3) @(negedge clock);
      sety(480); repeat (4) @(negedge clock);
      sety(0);   repeat (2) @(negedge clock);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] v;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      rd(STATUS, v);
      chk("reset_status", v, 32'h0);
      chk("reset_fs", {31'd0, frame_select}, 32'h0);
      chk("reset_irq", {31'd0, vblank_irq}, 32'h0);

      // basic flip to frame 1
      sety(100);
      wr(CTRL, 32'h1, 4'hF);
      rd(STATUS, v);
      chk("pending_set", v, 32'h2);
      sety(480);
      @(posedge clock); #1 chk("fs_one_clk_after_480", {31'd0, frame_select}, 32'h0);
      @(posedge clock); #1 chk("fs_two_clk_after_480", {31'd0, frame_select}, 32'h1);
      rd(STATUS, v);
      chk("status_after_flip", v, 32'h5);
      sety(0);
      wr(STATUS, 32'h4, 4'h1);
      rd(STATUS, v);
      chk("w1c_flag", v, 32'h1);

      // reset while a flip back to 0 is pending
      wr(CTRL, 32'h0, 4'h1);
      rd(STATUS, v);
      chk("pending_back", v, 32'h3);
      @(negedge clock); reset = 1'b0;
      @(negedge clock); reset = 1'b1;
      chk("fs_after_reset", {31'd0, frame_select}, 32'h0);
      rd(STATUS, v);
      chk("status_after_reset", v, 32'h0);
      run_frame();
      chk("pending_discarded", {31'd0, frame_select}, 32'h0);
      wr(STATUS, 32'h4, 4'h1);

      // request then cancel before vblank
      wr(CTRL, 32'h1, 4'h1);
      wr(CTRL, 32'h0, 4'h1);
      rd(STATUS, v);
      chk("cancel_status", v, 32'h0);
      run_frame();
      chk("cancel_fs", {31'd0, frame_select}, 32'h0);
      wr(STATUS, 32'h4, 4'h1);

      // CTRL = 3 written on the very cycle the edge acts
      sety(100); repeat (2) @(negedge clock);
      pixel_y_pos = 10'd480;
      @(negedge clock);
      bus_address = CTRL; bus_write_data = 32'h3; bus_byte_enable = 4'h1; bus_write_enable = 1'b1;
      @(posedge clock);
      #1 chk("coincident_fs", {31'd0, frame_select}, 32'h0);
      chk("coincident_irq", {31'd0, vblank_irq}, 32'h0);
      @(negedge clock); bus_write_enable = 1'b0; bus_byte_enable = '0;
      rd(STATUS, v);
      chk("coincident_status", v, 32'h6);
      chk("irq_level", {31'd0, vblank_irq}, 32'h1);
      sety(0);
      wr(STATUS, 32'h4, 4'h1);
      chk("irq_cleared", {31'd0, vblank_irq}, 32'h0);
      sety(100); repeat (2) @(negedge clock);
      sety(480);
      @(posedge clock); #1;
      @(posedge clock); #1 chk("deferred_flip", {31'd0, frame_select}, 32'h1);
      chk("irq_at_edge", {31'd0, vblank_irq}, 32'h1);

      // W1C on the edge cycle: set wins
      sety(0); repeat (2) @(negedge clock);
      wr(STATUS, 32'h4, 4'h1);
      sety(100); repeat (2) @(negedge clock);
      pixel_y_pos = 10'd480;
      @(negedge clock);
      bus_address = STATUS; bus_write_data = 32'h4; bus_byte_enable = 4'h1; bus_write_enable = 1'b1;
      @(negedge clock); bus_write_enable = 1'b0; bus_byte_enable = '0;
      rd(STATUS, v);
      chk("w1c_vs_edge", v & 32'h4, 32'h4);
      sety(0);

      // lane 0 gating and address decode
      wr(CTRL, 32'h0, 4'hE);
      rd(STATUS, v);
      chk("lane0_gate", v & 32'h2, 32'h0);
      rd(BASE + 32'hC, v);
      chk("offset_c_reads_0", v, 32'h0);
      rd(32'hFF20_0700, v);
      chk("foreign_addr_reads_0", v, 32'h0);
      rd(CTRL, v);
      chk("ctrl_readback", v, 32'h3);

      // frame counter over 3 frames from reset
      @(negedge clock); reset = 1'b0;
      @(negedge clock); reset = 1'b1;
      repeat (3) run_frame();
`ifdef FRAME_FLIP_COUNTER_EN
      rd(FCOUNT, v);
      chk("frame_count", v, 32'd3);
`else
      rd(FCOUNT, v);
      chk("frame_count", v, 32'd0);
`endif
      repeat (2) @(negedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
